// File: rtl/output_module_if.sv
// output_module_if: VC-side pop interface and downstream-FIFO write interface of one router output port
interface output_module_if #(
  parameter int DSIZE = 32,
  parameter int NPORT = 5
);
  logic [NPORT-1:0]       vc_req;
  logic [NPORT*DSIZE-1:0] vc_data;
  logic [NPORT-1:0]       vc_read;
  logic                   out_full;
  logic                   out_write;
  logic [DSIZE-1:0]       data_out;
  logic [2:0]             grant_sel;
  logic                   busy;
  modport master (
    input  vc_req, vc_data, out_full,
    output vc_read, out_write, data_out, grant_sel, busy
  );
  modport slave (
    output vc_req, vc_data, out_full,
    input  vc_read, out_write, data_out, grant_sel, busy
  );
endinterface

// File: rtl/output_module.sv
// output_module: round-robin pops one packet at a time from the requesting VCs and writes it downstream
module output_module #(
  parameter int MSB_SLOT = 5,
  parameter int DSIZE    = 1 << MSB_SLOT,
  parameter int NPORT    = 5
) (
  input  logic           clk,
  input  logic           reset,
  output_module_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  state_t     state;
  logic [2:0] ptr, g;
  logic       go;
  // later iterations override earlier ones, so offset 0 (ptr itself) has top priority
  function automatic logic [2:0] pick(input logic [4:0] req, input logic [2:0] p);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (req[3'((int'(p) + i) % 5)]) r = 3'((int'(p) + i) % 5);
    return r;
  endfunction
  assign g             = pick(bus.vc_req, ptr);
  assign go            = reset && |bus.vc_req && (state == IDLE || (state == SEND && !bus.out_full));
  assign bus.vc_read   = go ? NPORT'(1) << g : '0;
  assign bus.out_write = reset && state == SEND && !bus.out_full;
  assign bus.busy      = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      bus.grant_sel <= 3'b111;
      bus.data_out  <= '0;
    end else begin
      if (go) begin
        bus.grant_sel <= g;
        ptr           <= g == 3'd4 ? 3'd0 : g + 3'd1;
      end
      case (state)
        IDLE:  state <= go ? FETCH : IDLE;
        FETCH: begin
          bus.data_out <= bus.vc_data[bus.grant_sel*DSIZE +: DSIZE];
          state        <= SEND;
        end
        SEND: if (!bus.out_full) begin
          state <= go ? FETCH : IDLE;
          if (!go) bus.grant_sel <= 3'b111;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_module.sv
// tb_output_module: directed stimulus with a scoreboard of popped packets checked against downstream writes
module tb_output_module;
  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  output_module_if #(.DSIZE(32), .NPORT(5)) bus ();
  output_module dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // reads push the source's word; writes must pop it back in order
  always @(negedge clk) if (reset === 1'b1) begin
    if (bus.out_write) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected_write: observed %h expected no write", bus.data_out);
      end
      if (q.size() > 0) begin
        logic [31:0] e;
        e = q.pop_front();
        checks++;
        assert (bus.data_out === e) else begin
          errors++;
          $error("FAIL sb_data: observed %h expected %h", bus.data_out, e);
        end
      end
    end
    if (bus.vc_read != 5'b0) begin
      checks++;
      assert ($onehot(bus.vc_read) && (bus.vc_read & ~bus.vc_req) == 5'b0) else begin
        errors++;
        $error("FAIL read_legal: observed %b expected one-hot within %b", bus.vc_read, bus.vc_req);
      end
      for (int i = 0; i < 5; i++) if (bus.vc_read[i]) q.push_back(bus.vc_data[i*32 +: 32]);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    reset        = 1'b0;
    bus.vc_req   = 5'b11111;
    bus.out_full = 1'b0;
    for (int i = 0; i < 5; i++) bus.vc_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    #12;
    chk("rst_vc_read", 32'(bus.vc_read), 0);
    chk("rst_out_write", 32'(bus.out_write), 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_grant_sel", 32'(bus.grant_sel), 3'b111);
    chk("rst_busy", 32'(bus.busy), 0);
    bus.vc_req = 5'b0;
    @(negedge clk) reset = 1'b1;
    cyc();
    bus.vc_req = 5'b11111;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_read", 32'(bus.vc_read), 32'(1) << (k % 5));
      cyc();
      chk("rr_fetch_no_read", 32'(bus.vc_read), 0);
      chk("rr_grant", 32'(bus.grant_sel), 32'(k % 5));
      if (k == 5) bus.vc_req = 5'b0;
      cyc();
    end
    chk("rr_last_write", 32'(bus.out_write), 1);
    cyc();
    chk("rr_idle", 32'(bus.busy), 0);
    bus.vc_data[31:0] = 32'hDEADBEEF;
    bus.vc_req        = 5'b00001;
    #1;
    chk("single_read", 32'(bus.vc_read), 5'b00001);
    cyc();
    chk("single_grant", 32'(bus.grant_sel), 0);
    chk("single_fetch_no_write", 32'(bus.out_write), 0);
    bus.vc_req = 5'b0;
    cyc();
    chk("single_write", 32'(bus.out_write), 1);
    chk("single_data", bus.data_out, 32'hDEADBEEF);
    cyc();
    chk("single_idle_busy", 32'(bus.busy), 0);
    chk("single_idle_grant", 32'(bus.grant_sel), 3'b111);
    bus.vc_req = 5'b00010;
    #1;
    chk("bp_read", 32'(bus.vc_read), 5'b00010);
    cyc();
    bus.out_full = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_no_write", 32'(bus.out_write), 0);
      chk("bp_no_read", 32'(bus.vc_read), 0);
      chk("bp_data_held", bus.data_out, 32'hA000_0001);
      cyc();
    end
    bus.out_full = 1'b0;
    #1;
    chk("bp_release_write", 32'(bus.out_write), 1);
    chk("bp_release_read", 32'(bus.vc_read), 5'b00010);
    cyc();
    chk("bp_single_write", 32'(bus.out_write), 0);
    bus.vc_req = 5'b0;
    cyc();
    cyc();
    bus.vc_req = 5'b00100;
    #1;
    chk("ptr_read_e", 32'(bus.vc_read), 5'b00100);
    cyc();
    bus.vc_req = 5'b00011;
    cyc();
    chk("ptr_wrap_n", 32'(bus.vc_read), 5'b00001);
    cyc();
    chk("ptr_grant_n", 32'(bus.grant_sel), 0);
    cyc();
    chk("ptr_then_s", 32'(bus.vc_read), 5'b00010);
    cyc();
    bus.vc_req = 5'b0;
    cyc();
    cyc();
    bus.vc_req = 5'b00100;
    #1;
    chk("rst_mid_read", 32'(bus.vc_read), 5'b00100);
    cyc();
    bus.out_full = 1'b1;
    bus.vc_req   = 5'b0;
    cyc();
    chk("rst_mid_busy_before", 32'(bus.busy), 1);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_grant", 32'(bus.grant_sel), 3'b111);
    chk("rst_mid_data", bus.data_out, 0);
    bus.out_full = 1'b0;
    #1;
    chk("rst_mid_no_write", 32'(bus.out_write), 0);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("post_rst_no_write", 32'(bus.out_write), 0);
    end
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
